write_request_scheduler: RTL

Shares the single host write-request queue (sq_wr) between N_STREAMS per-stream writers and routes write completions (cq_wr) back to the stream that issued them. Round-robin arbitration is gated by per-stream and global outstanding-request credit limits, so one stream cannot starve the others or overrun the completion path. The block sits between the per-stream writers and the shell's sq_wr/cq_wr ports. It replaces the separate request arbiter and completion demultiplexer with one credit-aware scheduler.

---
 rtl/write_request_scheduler_pkg.sv | 20 ++
 rtl/write_request_scheduler_rr_arbiter.sv | 29 ++
 rtl/write_request_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/write_request_scheduler_pkg.sv
// Shared types, widths and helpers for the write-request scheduler.
package write_request_scheduler_pkg;

   localparam int unsigned REQ_W_DEF     = 128;
   localparam int unsigned STRM_ID_W_MAX = 4;

   localparam int unsigned ERR_W            = 1;
   localparam int unsigned ERR_UNEXP_CQ_BIT = 0;

   typedef struct packed {
      logic [REQ_W_DEF-1:0]     payload;
      logic [STRM_ID_W_MAX-1:0] id;
   } sched_req_t;

   // A single stream still needs a one-bit id.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/write_request_scheduler_rr_arbiter.sv
// Round-robin priority encoder: first asserted request at or after ptr wins.
module write_request_scheduler_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = IDX_W'((32'(ptr) + off) % N);
         if (!gnt_valid && req[idx]) begin
            gnt[idx]  = 1'b1;
            gnt_idx   = idx;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/write_request_scheduler.sv
// Credit-aware round-robin scheduler onto sq_wr, with cq_wr completion routing.
module write_request_scheduler
   import write_request_scheduler_pkg::*;
#(
   parameter  int unsigned N_STREAMS     = 4,
   parameter  int unsigned REQ_W         = 128,
   parameter  int unsigned MAX_OUT_STRM  = 8,
   parameter  int unsigned MAX_OUT_TOTAL = 16,
   localparam int unsigned ID_W          = id_width(N_STREAMS),
   localparam int unsigned TOT_W         = $clog2(MAX_OUT_TOTAL + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sched_en,
   input  logic [N_STREAMS-1:0]         req_valid,
   output logic [N_STREAMS-1:0]         req_ready,
   input  logic [N_STREAMS*REQ_W-1:0]   req_data,
   output logic                         sq_valid,
   input  logic                         sq_ready,
   output logic [REQ_W-1:0]             sq_data,
   output logic [ID_W-1:0]              sq_strm,
   input  logic                         cq_valid,
   output logic                         cq_ready,
   input  logic [ID_W-1:0]              cq_strm,
   output logic [N_STREAMS-1:0]         cmpl_valid,
   output logic [TOT_W-1:0]             outstanding_total,
   output logic                         idle,
   output logic                         err_unexpected_cq
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT_STRM + 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [REQ_W-1:0]       sq_data_q, sq_data_d;
   logic [ID_W-1:0]        sq_strm_q, sq_strm_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       cnt_q [N_STREAMS];
   logic [CNT_W-1:0]       cnt_d [N_STREAMS];
   logic [TOT_W-1:0]       total_q, total_d;
   logic [N_STREAMS-1:0]   cmpl_q, cmpl_d;
   logic                   idle_q, idle_d;
   logic [ERR_W-1:0]       err_q, err_d;

   logic [REQ_W-1:0]       req_arr [N_STREAMS];
   logic [N_STREAMS-1:0]   elig;
   logic [N_STREAMS-1:0]   gnt;
   logic [ID_W-1:0]        gnt_idx;
   logic                   gnt_valid;
   logic                   held_hs;
   logic [N_STREAMS-1:0]   inc;
   logic [N_STREAMS-1:0]   dec;

   for (genvar g = 0; g < N_STREAMS; g++) begin : g_unpack
      assign req_arr[g] = req_data[g*REQ_W +: REQ_W];
   end

   assign held_hs = (state_q == ST_HELD) && sq_ready;

   // Eligibility counts the held request as already outstanding.
   always_comb begin
      int unsigned own_cnt;
      int unsigned total_eff;
      logic        can_grant;
      elig      = '0;
      own_cnt   = 0;
      can_grant = rst_n && sched_en && ((state_q == ST_EMPTY) || sq_ready);
      total_eff = 32'(total_q) + ((state_q == ST_HELD) ? 32'd1 : 32'd0);
      for (int unsigned i = 0; i < N_STREAMS; i++) begin
         own_cnt = 32'(cnt_q[i]) +
                   (((state_q == ST_HELD) && (32'(sq_strm_q) == i)) ? 32'd1 : 32'd0);
         elig[i] = can_grant && req_valid[i] &&
                   (own_cnt < MAX_OUT_STRM) && (total_eff < MAX_OUT_TOTAL);
      end
   end

   write_request_scheduler_rr_arbiter #(
      .N     (N_STREAMS),
      .IDX_W (ID_W)
   ) u_rr_arbiter (
      .req       (elig),
      .ptr       (rr_ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Output register: load on grant, release on handshake.
   always_comb begin
      state_d   = state_q;
      sq_data_d = sq_data_q;
      sq_strm_d = sq_strm_q;
      rr_ptr_d  = rr_ptr_q;
      if (held_hs) begin
         state_d = ST_EMPTY;
      end
      if (gnt_valid) begin
         state_d   = ST_HELD;
         sq_data_d = req_arr[gnt_idx];
         sq_strm_d = gnt_idx;
         rr_ptr_d  = ID_W'((32'(gnt_idx) + 1) % N_STREAMS);
      end
   end

   // Credit counters; a completion for a stream at zero is flagged and ignored.
   always_comb begin
      inc   = '0;
      dec   = '0;
      err_d = err_q;
      for (int unsigned i = 0; i < N_STREAMS; i++) begin
         inc[i]   = held_hs && (32'(sq_strm_q) == i);
         dec[i]   = cq_valid && (32'(cq_strm) == i) && (cnt_q[i] != '0);
         cnt_d[i] = cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
      end
      if (cq_valid && (dec == '0)) begin
         err_d[ERR_UNEXP_CQ_BIT] = 1'b1;
      end
      total_d = total_q + TOT_W'(held_hs) - TOT_W'(|dec);
      cmpl_d  = dec;
      idle_d  = (state_d == ST_EMPTY) && (total_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         sq_data_q <= '0;
         sq_strm_q <= '0;
         rr_ptr_q  <= '0;
         total_q   <= '0;
         cmpl_q    <= '0;
         idle_q    <= 1'b1;
         err_q     <= '0;
         for (int unsigned i = 0; i < N_STREAMS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sq_data_q <= sq_data_d;
         sq_strm_q <= sq_strm_d;
         rr_ptr_q  <= rr_ptr_d;
         total_q   <= total_d;
         cmpl_q    <= cmpl_d;
         idle_q    <= idle_d;
         err_q     <= err_d;
         for (int unsigned i = 0; i < N_STREAMS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign req_ready         = gnt;
   assign sq_valid          = (state_q == ST_HELD);
   assign sq_data           = sq_data_q;
   assign sq_strm           = sq_strm_q;
   assign cq_ready          = 1'b1;
   assign cmpl_valid        = cmpl_q;
   assign outstanding_total = total_q;
   assign idle              = idle_q;
   assign err_unexpected_cq = err_q[ERR_UNEXP_CQ_BIT];

endmodule
